// File: rtl/fifo_skid_buf.sv
// Two-entry register buffer between the FIFO read port and the output stream.
// Head is always the oldest word; a push and a pop in the same cycle keep order.
module fifo_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [1:0]       o_occ,
  output logic [WIDTH-1:0] o_head
);

  localparam logic [1:0] DEPTH = 2'd2;

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({i_push, i_pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = i_data;
        else               tail_d = i_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged: the new word goes behind whatever remains.
        if (occ_q == DEPTH) begin
          head_d = tail_q;
          tail_d = i_data;
        end else begin
          head_d = i_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign o_occ  = occ_q;
  assign o_head = head_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a one-cycle-latency FIFO read port into a valid/ready stream and
// frames it into bursts of programmable length with o_last on the final beat.
module fifo_stream_reader #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rd_en,
  input  logic [WIDTH-1:0] i_fifo_rd_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  input  logic [LEN_W-1:0] i_burst_len,
  output logic             o_busy
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic             pend_q, pend_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic [1:0]       occ;
  logic [WIDTH-1:0] head;
  logic             pop_out;
  logic [2:0]       occ_after;
  logic [LEN_W-1:0] len_req;
  logic [LEN_W-1:0] len_cur;
  logic             at_last;

  fifo_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (pend_q),
    .i_data  (i_fifo_rd_data),
    .i_pop   (pop_out),
    .o_occ   (occ),
    .o_head  (head)
  );

  assign o_valid = (occ != 2'd0);
  assign o_data  = head;
  assign pop_out = o_valid & i_ready;
  assign o_busy  = o_valid | pend_q;

  // Count words already owned (buffered + in flight) after this cycle's pop;
  // pop_out implies occ >= 1, so this never underflows.
  assign occ_after    = {1'b0, occ} + {2'b00, pend_q} - {2'b00, pop_out};
  assign o_fifo_rd_en = i_rst_n & ~i_fifo_empty & (occ_after < 3'd2);

  // Before the first beat of a burst the live input sets the length; after
  // that the latched copy is used so mid-burst changes are ignored.
  assign len_req = (i_burst_len == '0) ? LEN_ONE : i_burst_len;
  assign len_cur = (cnt_q == '0) ? len_req : len_q;
  assign at_last = (cnt_q == len_cur - LEN_ONE);
  assign o_last  = o_valid & at_last;

  always_comb begin
    pend_d = o_fifo_rd_en;
    cnt_d  = cnt_q;
    len_d  = len_q;
    if (pop_out) begin
      if (cnt_q == '0) len_d = len_req;
      cnt_d = at_last ? '0 : cnt_q + LEN_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
      len_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader with a behavioural FIFO model.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty;
  logic       rd_en;
  logic [7:0] rd_data = 8'h00;
  logic       valid;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       last;
  logic [3:0] blen = 4'd4;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO read port: one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 8'd1;
    end
  end

  fifo_stream_reader #(.WIDTH(8), .LEN_W(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_fifo_empty   (fifo_empty),
    .o_fifo_rd_en   (rd_en),
    .i_fifo_rd_data (rd_data),
    .o_valid        (valid),
    .i_ready        (ready),
    .o_data         (data),
    .o_last         (last),
    .i_burst_len    (blen),
    .o_busy         (busy)
  );

  typedef struct {
    int         n;
    logic [3:0] blen_a;
    logic [3:0] blen_b;
    int         sw;
    logic [15:0] rdy;
    logic [15:0] lastm;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push_words(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = base + 8'(i);
      wr_ptr = wr_ptr + 8'd1;
    end
  endtask

  task automatic drain(input int n, input logic [7:0] base, input string name);
    int got;
    got = 0;
    for (int c = 0; c < 100 && got < n; c++) begin
      if (valid && ready) begin
        check({name, "_data"}, 32'(data), 32'(base + 8'(got)));
        got++;
      end
      tick();
    end
    check({name, "_count"}, 32'(got), 32'(n));
  endtask

  initial begin
    tbl[0] = '{n: 16, blen_a: 4'd4, blen_b: 4'd4, sw: 99, rdy: 16'hFFFF, lastm: 16'h8888};
    tbl[1] = '{n: 8,  blen_a: 4'd0, blen_b: 4'd0, sw: 99, rdy: 16'h5555, lastm: 16'h00FF};
    tbl[2] = '{n: 8,  blen_a: 4'd4, blen_b: 4'd2, sw: 1,  rdy: 16'hFFFF, lastm: 16'h00A8};
    tbl[3] = '{n: 6,  blen_a: 4'd3, blen_b: 4'd3, sw: 99, rdy: 16'h3333, lastm: 16'h0024};
    tbl[4] = '{n: 5,  blen_a: 4'd1, blen_b: 4'd1, sw: 99, rdy: 16'hFFFF, lastm: 16'h001F};

    // Reset state
    #12;
    check("rst_valid", 32'(valid), 0);
    check("rst_last",  32'(last),  0);
    check("rst_busy",  32'(busy),  0);
    check("rst_data",  32'(data),  0);
    check("rst_rd_en", 32'(rd_en), 0);

    // Latency from empty FIFO
    do_reset();
    blen = 4'd4;
    ready = 1'b1;
    mem[wr_ptr] = 8'h11; wr_ptr = wr_ptr + 8'd1;
    mem[wr_ptr] = 8'h22; wr_ptr = wr_ptr + 8'd1;
    mem[wr_ptr] = 8'h33; wr_ptr = wr_ptr + 8'd1;
    #1;
    check("lat_rd_en_t0", 32'(rd_en), 1);
    check("lat_valid_t0", 32'(valid), 0);
    tick();
    check("lat_valid_t1", 32'(valid), 0);
    check("lat_busy_t1",  32'(busy),  1);
    tick();
    check("lat_valid_t2", 32'(valid), 1);
    check("lat_data0",    32'(data),  32'h11);
    check("lat_last0",    32'(last),  0);
    tick();
    check("lat_data1", 32'(data), 32'h22);
    check("lat_last1", 32'(last), 0);
    tick();
    check("lat_data2", 32'(data), 32'h33);
    check("lat_last2", 32'(last), 0);
    tick();
    check("lat_valid_end", 32'(valid), 0);
    check("lat_busy_end",  32'(busy),  0);

    // Table-driven burst framing / throughput scenarios
    for (int s = 0; s < 5; s++) begin
      int hs;
      int first_c;
      int last_c;
      logic [7:0] base;
      do_reset();
      base = 8'(16 * (s + 1));
      blen = tbl[s].blen_a;
      push_words(tbl[s].n, base);
      hs = 0;
      first_c = -1;
      last_c = 0;
      for (int c = 0; c < 200 && hs < tbl[s].n; c++) begin
        ready = tbl[s].rdy[c % 16];
        #1;
        if (valid && ready) begin
          check($sformatf("tbl%0d_data%0d", s, hs), 32'(data), 32'(base + 8'(hs)));
          check($sformatf("tbl%0d_last%0d", s, hs), 32'(last), 32'(tbl[s].lastm[hs]));
          if (first_c < 0) first_c = c;
          last_c = c;
          if (hs == tbl[s].sw) blen = tbl[s].blen_b;
          hs++;
        end
        @(posedge clk);
        #1;
      end
      check($sformatf("tbl%0d_beats", s), 32'(hs), 32'(tbl[s].n));
      if (tbl[s].rdy == 16'hFFFF)
        check($sformatf("tbl%0d_span", s), 32'(last_c - first_c), 32'(tbl[s].n - 1));
      ready = 1'b1;
      tick();
      tick();
      check($sformatf("tbl%0d_idle_valid", s), 32'(valid), 0);
      check($sformatf("tbl%0d_idle_busy", s),  32'(busy),  0);
    end

    // Backpressure: hold ready low for 5 cycles
    begin
      int pops;
      do_reset();
      blen = 4'd4;
      push_words(8, 8'h50);
      #1;
      pops = 0;
      for (int c = 0; c < 5; c++) begin
        if (rd_en) pops++;
        if (c >= 2) begin
          check($sformatf("bp_hold_valid%0d", c), 32'(valid), 1);
          check($sformatf("bp_hold_data%0d", c),  32'(data),  32'h50);
        end
        tick();
      end
      check("bp_pops", 32'(pops), 2);
      check("bp_busy", 32'(busy), 1);
      ready = 1'b1;
      #1;
      drain(8, 8'h50, "bp");
      check("bp_idle_valid", 32'(valid), 0);
    end

    // Asynchronous reset mid-clock with words buffered and a read pending
    do_reset();
    blen = 4'd4;
    push_words(8, 8'hA0);
    #1;
    check("ar_rd_en_t0", 32'(rd_en), 1);
    tick();
    tick();
    check("ar_busy_pre", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(valid), 0);
    check("ar_last",  32'(last),  0);
    check("ar_busy",  32'(busy),  0);
    check("ar_rd_en", 32'(rd_en), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready = 1'b1;
    #1;
    check("ar_rd_en_r0", 32'(rd_en), 1);
    tick();
    check("ar_valid_r1", 32'(valid), 0);
    tick();
    check("ar_valid_r2", 32'(valid), 1);
    check("ar_data_r2",  32'(data),  32'hA2);
    drain(6, 8'hA2, "ar");
    tick();
    check("ar_idle_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule
